// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: serial memory controller.
// A request accepted in IDLE sends a command bit, 8 address bits and (for a
// write) 8 data bits LSB first on o_miso. A read then waits for i_ready and
// shifts 8 bits in from i_mosi. Every operation ends by waiting for i_op_done.
// Optional feature macro: SPI_MEM_CTRL_TIMEOUT_EN adds the TIMEOUT_CYCLES
// parameter, a 16-bit wait counter and the o_err port.
module spi_mem_ctrl
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_newd,
    input  logic       i_wr,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic       o_done,
    output logic       o_busy,
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    output logic       o_err,
`endif
    output logic       o_cs,
    output logic       o_miso,
    input  logic       i_mosi,
    input  logic       i_ready,
    input  logic       i_op_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RWAIT,
        S_RDATA,
        S_WAIT_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    logic [2:0]  r_bit_cnt;
    logic        r_wr;
    logic [7:0]  r_addr;
    logic [7:0]  r_din;
    logic [7:0]  r_rx;
    logic [7:0]  r_dout;
    logic        r_done;
    logic        w_accept;
    logic        w_block;
    logic        w_done_set;
    logic        w_cs_n;
    logic        w_miso;
    logic        w_to_hit;

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_to_cnt;
    logic        r_err;
    logic        w_err_set;
`endif

    // Reset synchronizer: assertion is immediate, release follows two clock edges.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    assign w_to_hit = (r_to_cnt == TO_LAST);
`else
    assign w_to_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode and serial-side outputs; cs is low in every non-IDLE state.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_set  = 1'b0;
        w_cs_n      = 1'b1;
        w_miso      = 1'b0;
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
        w_err_set   = 1'b0;
        w_block     = r_done | r_err;
`else
        w_block     = r_done;
`endif
        case (r_state)
            S_IDLE: begin
                // The done/err cycle itself sits in IDLE but must not accept.
                if (i_newd && !w_block && w_rst_n) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                w_cs_n      = 1'b0;
                w_miso      = r_wr;
                w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                w_cs_n = 1'b0;
                w_miso = r_addr[r_bit_cnt];
                if (r_bit_cnt == 3'd7) w_state_nxt = r_wr ? S_WDATA : S_RWAIT;
            end
            S_WDATA: begin
                w_cs_n = 1'b0;
                w_miso = r_din[r_bit_cnt];
                if (r_bit_cnt == 3'd7) w_state_nxt = S_WAIT_DONE;
            end
            S_RWAIT: begin
                w_cs_n = 1'b0;
                // Data bit0 arrives in the same cycle ready is first seen.
                if (i_ready) begin
                    w_state_nxt = S_RDATA;
                end else if (w_to_hit) begin
                    w_state_nxt = S_IDLE;
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
                    w_err_set   = 1'b1;
`endif
                end
            end
            S_RDATA: begin
                w_cs_n = 1'b0;
                // Bits 1..7: seven more cycles after the ready cycle.
                if (r_bit_cnt == 3'd6) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                w_cs_n = 1'b0;
                if (i_op_done) begin
                    w_state_nxt = S_IDLE;
                    w_done_set  = 1'b1;
                end else if (w_to_hit) begin
                    w_state_nxt = S_IDLE;
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
                    w_err_set   = 1'b1;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, bit counter, receive shifter and the done/dout registers.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr      <= 1'b0;
            r_addr    <= 8'h00;
            r_din     <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_rx      <= 8'h00;
            r_dout    <= 8'h00;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_accept) begin
                r_wr   <= i_wr;
                r_addr <= i_addr;
                r_din  <= i_din;
            end
            if (r_state != w_state_nxt)
                r_bit_cnt <= 3'd0;
            else if (r_state == S_ADDR || r_state == S_WDATA || r_state == S_RDATA)
                r_bit_cnt <= r_bit_cnt + 3'd1;
            // LSB first: shifting right leaves the first bit in position 0.
            if ((r_state == S_RWAIT && i_ready) || r_state == S_RDATA)
                r_rx <= {i_mosi, r_rx[7:1]};
            // dout only changes when a read actually completes.
            if (w_done_set && !r_wr)
                r_dout <= r_rx;
        end
    end

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    // Wait counter: restarts on every state change, counts only in the wait states.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_to_cnt <= 16'd0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_err_set;
            if (r_state != w_state_nxt)
                r_to_cnt <= 16'd0;
            else if (r_state == S_RWAIT || r_state == S_WAIT_DONE)
                r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign o_err = r_err;
`endif

    assign o_cs   = w_cs_n;
    assign o_miso = w_miso;
    assign o_done = r_done;
    assign o_dout = r_dout;
    assign o_busy = (r_state != S_IDLE) | r_done | w_accept;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: write/read framing, waits, reset abort,
// request filtering, back-to-back operations and (if enabled) timeout.
module tb_spi_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       newd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] din = 8'h00;
    logic       mosi = 1'b0;
    logic       ready = 1'b0;
    logic       op_done = 1'b0;
    logic [7:0] dout;
    logic       done;
    logic       busy;
    logic       cs;
    logic       miso;
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    logic       err;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_dout = 8'h00;

    always #5 clk = ~clk;

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    spi_mem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
`else
    spi_mem_ctrl dut (
`endif
        .i_clk(clk), .i_rst(rst), .i_newd(newd), .i_wr(wr), .i_addr(addr),
        .i_din(din), .o_dout(dout), .o_done(done), .o_busy(busy),
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
        .o_err(err),
`endif
        .o_cs(cs), .o_miso(miso), .i_mosi(mosi), .i_ready(ready),
        .i_op_done(op_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // One idle cycle with no request: nothing may be in flight.
    task automatic check_idle(input string tag);
        tick(); newd = 1'b0;
        samp();
        checks++;
        if (busy !== 1'b0 || cs !== 1'b1 || done !== 1'b0 || miso !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b cs=%b done=%b miso=%b, want 0 1 0 0", tag, busy, cs, done, miso);
        end
        checks++;
        if (dout !== exp_dout) begin
            errors++;
            $display("FAIL %s idle_dout: got %h want %h", tag, dout, exp_dout);
        end
    endtask

    // Full write transaction with framing checks on every cycle.
    task automatic run_write(input string tag, input logic [7:0] a, input logic [7:0] d,
                             input int opdly, input bit spam, input bit spurious,
                             input bit newd_on_done);
        logic [16:0] seq;
        seq = {d, a, 1'b1};
        tick(); newd = 1'b1; wr = 1'b1; addr = a; din = d; op_done = 1'b0; ready = 1'b0;
        samp();
        checks++;
        if (busy !== 1'b1 || cs !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b cs=%b done=%b, want 1 1 0", tag, busy, cs, done);
        end
        for (int k = 1; k <= 17; k++) begin
            tick(); newd = spam; wr = 1'b0; addr = ~a; din = ~d;
            op_done = spurious && (k == 5);
            ready   = spurious && (k == 6);
            samp();
            checks++;
            if (cs !== 1'b0 || miso !== seq[k-1] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s shift k=%0d: cs=%b miso=%b busy=%b done=%b, want 0 %b 1 0",
                         tag, k, cs, miso, busy, done, seq[k-1]);
            end
        end
        for (int j = 0; j <= opdly; j++) begin
            tick(); op_done = (j == opdly); ready = 1'b0; newd = spam;
            samp();
            checks++;
            if (cs !== 1'b0 || miso !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s wait j=%0d: cs=%b miso=%b busy=%b done=%b, want 0 0 1 0",
                         tag, j, cs, miso, busy, done);
            end
        end
        tick(); op_done = 1'b0; newd = newd_on_done;
        samp();
        checks++;
        if (done !== 1'b1 || cs !== 1'b1 || miso !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done_cycle: done=%b cs=%b miso=%b busy=%b, want 1 1 0 1",
                     tag, done, cs, miso, busy);
        end
    endtask

    // Full read transaction; memory answers after rdy_dly RWAIT cycles.
    task automatic run_read(input string tag, input logic [7:0] a, input int rdy_dly,
                            input logic [7:0] data, input int opdly, input bit newd_on_done);
        logic [8:0] seq;
        seq = {a, 1'b0};
        tick(); newd = 1'b1; wr = 1'b0; addr = a; op_done = 1'b0; ready = 1'b0;
        samp();
        checks++;
        if (busy !== 1'b1 || cs !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: busy=%b cs=%b, want 1 1", tag, busy, cs);
        end
        for (int k = 1; k <= 9; k++) begin
            tick(); newd = 1'b0; addr = ~a; ready = (k == 4);
            samp();
            checks++;
            if (cs !== 1'b0 || miso !== seq[k-1] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s hdr k=%0d: cs=%b miso=%b busy=%b done=%b, want 0 %b 1 0",
                         tag, k, cs, miso, busy, done, seq[k-1]);
            end
        end
        for (int j = 0; j < rdy_dly; j++) begin
            tick(); ready = 1'b0;
            samp();
            checks++;
            if (cs !== 1'b0 || miso !== 1'b0 || busy !== 1'b1 || dout !== exp_dout) begin
                errors++;
                $display("FAIL %s rwait j=%0d: cs=%b miso=%b busy=%b dout=%h, want 0 0 1 %h",
                         tag, j, cs, miso, busy, dout, exp_dout);
            end
        end
        for (int b = 0; b < 8; b++) begin
            tick(); ready = (b == 0); mosi = data[b];
            samp();
            checks++;
            if (cs !== 1'b0 || miso !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s rdata b=%0d: cs=%b miso=%b done=%b, want 0 0 0", tag, b, cs, miso, done);
            end
        end
        for (int j = 0; j <= opdly; j++) begin
            tick(); ready = 1'b0; mosi = 1'b0; op_done = (j == opdly);
            samp();
            checks++;
            if (cs !== 1'b0 || done !== 1'b0 || dout !== exp_dout) begin
                errors++;
                $display("FAIL %s rdone_wait j=%0d: cs=%b done=%b dout=%h, want 0 0 %h",
                         tag, j, cs, done, dout, exp_dout);
            end
        end
        tick(); op_done = 1'b0; newd = newd_on_done;
        samp();
        checks++;
        if (done !== 1'b1 || cs !== 1'b1 || dout !== data || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done_cycle: done=%b cs=%b dout=%h busy=%b, want 1 1 %h 1",
                     tag, done, cs, dout, busy, data);
        end
        exp_dout = data;
    endtask

    task automatic test_reset();
        rst = 1'b0; newd = 1'b1; wr = 1'b1;
        tick();
        samp();
        checks++;
        if (cs !== 1'b1 || miso !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL reset: cs=%b miso=%b done=%b busy=%b dout=%h, want 1 0 0 0 00",
                     cs, miso, done, busy, dout);
        end
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b want 0", err);
        end
`endif
        tick(); newd = 1'b0; rst = 1'b1;
        repeat (3) tick();
        check_idle("reset_release");
    endtask

    task automatic test_write();
        run_write("write", 8'h5A, 8'hC3, 2, 1'b0, 1'b0, 1'b0);
        check_idle("write");
    endtask

    task automatic test_read();
        run_read("read", 8'h5A, 4, 8'h3C, 1, 1'b0);
        check_idle("read");
    endtask

    task automatic test_newd_spam();
        run_write("spam", 8'hA5, 8'h0F, 3, 1'b1, 1'b0, 1'b0);
        check_idle("spam");
    endtask

    task automatic test_spurious();
        run_write("spurious", 8'h3C, 8'h96, 0, 1'b0, 1'b1, 1'b0);
        check_idle("spurious");
    endtask

    task automatic test_back_to_back();
        run_write("b2b_w", 8'h81, 8'h7E, 0, 1'b0, 1'b0, 1'b1);
        run_read("b2b_r", 8'hC5, 0, 8'hA7, 0, 1'b1);
        check_idle("b2b");
    endtask

    task automatic test_reset_mid();
        tick(); newd = 1'b1; wr = 1'b1; addr = 8'h5A; din = 8'hC3;
        tick(); newd = 1'b0;
        repeat (3) tick();
        tick(); rst = 1'b0;
        samp();
        checks++;
        if (cs !== 1'b1 || miso !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: cs=%b miso=%b busy=%b done=%b, want 1 0 0 0", cs, miso, busy, done);
        end
        exp_dout = 8'h00;
        for (int j = 0; j < 6; j++) begin
            tick(); op_done = 1'b1; rst = (j < 2) ? 1'b0 : 1'b1;
            samp();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || cs !== 1'b1 || dout !== 8'h00) begin
                errors++;
                $display("FAIL rst_mid_after j=%0d: done=%b busy=%b cs=%b dout=%h, want 0 0 1 00",
                         j, done, busy, cs, dout);
            end
        end
        op_done = 1'b0;
        run_write("rst_mid_next", 8'h5A, 8'hC3, 1, 1'b0, 1'b0, 1'b0);
        check_idle("rst_mid_next");
    endtask

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        tick(); newd = 1'b1; wr = 1'b0; addr = 8'h5A; ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick(); newd = 1'b0;
        end
        for (int j = 0; j < 16; j++) begin
            tick();
            samp();
            checks++;
            if (cs !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL timeout_wait j=%0d: cs=%b err=%b busy=%b, want 0 0 1", j, cs, err, busy);
            end
        end
        tick();
        samp();
        checks++;
        if (err !== 1'b1 || cs !== 1'b1 || done !== 1'b0 || dout !== exp_dout) begin
            errors++;
            $display("FAIL timeout_err: err=%b cs=%b done=%b dout=%h, want 1 1 0 %h",
                     err, cs, done, dout, exp_dout);
        end
        tick();
        samp();
        checks++;
        if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cs !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: err=%b done=%b busy=%b cs=%b, want 0 0 0 1", err, done, busy, cs);
        end
    endtask
`else
    task automatic test_long_wait();
        run_write("long_wait", 8'h12, 8'h34, 300, 1'b0, 1'b0, 1'b0);
        check_idle("long_wait");
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_newd_spam();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
